// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One shared 64-bit accumulator serves both shift-add multiply and restoring divide.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opv1,
  input  logic [31:0] opv2,
  input  logic        annul,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        ov_q, ov_d;
  logic [31:0] v1_q, v1_d;

  logic        sgn1, sgn2, s1, s2;
  logic        is_dz, is_ov, accept;
  logic [31:0] mag1, mag2;

  assign sgn1 = op[2] ? ~op[0] : (op[1:0] != 2'd3);
  assign sgn2 = op[2] ? ~op[0] : ~op[1];
  assign s1 = sgn1 & opv1[31];
  assign s2 = sgn2 & opv2[31];
  assign mag1 = s1 ? (32'd0 - opv1) : opv1;
  assign mag2 = s2 ? (32'd0 - opv2) : opv2;
  assign is_dz = op[2] & (opv2 == 32'd0);
  assign is_ov = op[2] & ~op[0] & (opv1 == 32'h8000_0000)
               & (opv2 == 32'hFFFF_FFFF);
  assign accept = (state_q == S_IDLE) & start & ~annul;

  // Multiply: add into the upper half, shift product bits down into the lower half
  logic [32:0] mul_sum;
  logic [63:0] acc_mul;
  assign mul_sum = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
  assign acc_mul = {mul_sum, acc_q[31:1]};

  // Divide: upper half is the partial remainder, lower half collects quotient bits
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        borrow;
  logic [31:0] rem_nx;
  logic [63:0] acc_div;
  logic        div_unused;
  assign rem_sh  = {acc_q[63:32], a_q[31]};
  assign diff    = {1'b0, rem_sh} - {2'b00, b_q};
  assign borrow  = diff[33];
  assign rem_nx  = borrow ? rem_sh[31:0] : diff[31:0];
  assign acc_div = {rem_nx, acc_q[30:0], ~borrow};
  assign div_unused = diff[32];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    v1_d    = v1_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = op;
          a_d    = mag1;
          b_d    = mag2;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          dz_d   = is_dz;
          ov_d   = is_ov;
          v1_d   = opv1;
          if (is_dz | is_ov) begin
            state_d = S_DONE;
          end else begin
            acc_d   = 64'd0;
            cnt_d   = 5'd0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = acc_div;
          a_d   = {a_q[30:0], 1'b0};
        end else begin
          acc_d = acc_mul;
          b_d   = {1'b0, b_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (annul) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      v1_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      v1_q    <= v1_d;
    end
  end

  logic [63:0] prod;
  logic [31:0] quot, rem, res_sel;

  always_comb begin
    prod = neg_q ? (64'd0 - acc_q) : acc_q;
    quot = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (dz_q) begin
      quot = 32'hFFFF_FFFF;
      rem  = v1_q;
    end else if (ov_q) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end
    unique case (op_q)
      3'd0:    res_sel = prod[31:0];
      3'd1,
      3'd2,
      3'd3:    res_sel = prod[63:32];
      3'd4,
      3'd5:    res_sel = quot;
      default: res_sel = rem;
    endcase
  end

  assign done      = (state_q == S_DONE);
  assign result    = done ? res_sel : 32'd0;
  assign stall_req = (state_q == S_CALC) | accept;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed vectors, decoupled done monitor.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [2:0]  op;
  logic [31:0] opv1, opv2;
  logic        stall_req, done;
  logic [31:0] result;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opv1      (opv1),
    .opv2      (opv2),
    .annul     (annul),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done cyc=%0d actual=%h required=no_done",
                   cyc, result);
        end else begin
          e = q.pop_front();
          chk({e.name, "_data"}, result, e.data);
          chk({e.name, "_cycle"}, cyc, e.at);
        end
      end else begin
        chk("idle_result_zero", result, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input int lat, input string nm);
    int n0;
    int st;
    @(posedge clk); #1;
    start = 1'b1; op = o; opv1 = a; opv2 = b;
    n0 = cyc;
    q.push_back('{r, n0 + lat, nm});
    @(negedge clk);
    chk({nm, "_stall_acc"}, stall_req, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'(~o);
    opv1 = $urandom;
    opv2 = $urandom;
    st = 1;
    repeat (lat) begin
      @(negedge clk);
      if (stall_req) st++;
    end
    chk({nm, "_stall_cycles"}, st, lat);
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; annul = 1'b0;
    op = 3'd0; opv1 = 32'd0; opv2 = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_stall", stall_req, 1'b0);
    chk("reset_done", done, 1'b0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_signed");
    run_op(3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 33, "mul_low");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem_by0");

    // flush mid-divide, then a fresh multiply on the following cycle
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; opv1 = 32'd1000; opv2 = 32'd3;
    n0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < n0 + 10) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("flush_stall", stall_req, 1'b0);
    chk("flush_done", done, 1'b0);
    #1;
    start = 1'b1; op = 3'd0; opv1 = 32'd6; opv2 = 32'd7;
    q.push_back('{32'd42, n0 + 44, "flush_mul"});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (34) @(posedge clk);

    // reset during CALC
    #1;
    start = 1'b1; op = 3'd5; opv1 = 32'd100; opv2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    repeat (40) @(posedge clk);

    // start held through DONE restarts only on the following IDLE cycle
    #1;
    start = 1'b1; op = 3'd0; opv1 = 32'd3; opv2 = 32'd5;
    n0 = cyc;
    q.push_back('{32'd15, n0 + 33, "hold1"});
    while (cyc < n0 + 33) begin
      @(posedge clk); #1;
    end
    opv1 = 32'd4;
    @(negedge clk);
    chk("hold_done_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    q.push_back('{32'd20, n0 + 67, "hold2"});
    @(negedge clk);
    chk("hold_restart_stall", stall_req, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (36) @(posedge clk);

    @(negedge clk);
    chk("pending_results", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide sequencer for the execute stage, implementing the eight RV32M operations on a shared 64-bit shift/accumulate datapath. It accepts one operation from the EX stage and holds the pipeline with a stall request while it iterates. It presents the 32-bit result for the final cycle so EX can forward it as its register write data. It sits beside the EX logic unit, which selects its result when the decoded instruction is an M-extension op.

## Interface

Parameters:
- none; the data width is fixed at 32 bits (`RegBus`).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  EX holds a valid M-extension instruction; sampled only in IDLE.
- op  in  3  operation select, funct3 encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- opv1  in  32  rs1 operand (multiplicand/dividend); sampled with start.
- opv2  in  32  rs2 operand (multiplier/divisor); sampled with start.
- annul  in  1  pipeline flush; aborts any operation in flight.
- stall_req  out  1  hold IF/ID/EX; reset 0.
- done  out  1  result valid this cycle; reset 0.
- result  out  32  operation result; reset 0, 0 whenever done=0.

## Operation

State machine with states IDLE, CALC and DONE; reset and annul force IDLE.

- **IDLE.** When start=1 and annul=0, latch op, the operand magnitudes, the result sign and the special-case flags.
  - Divide by zero or signed overflow: go to DONE.
  - Otherwise: clear the 64-bit accumulator and the 5-bit counter, and go to CALC.
- **CALC.** Execute one iteration per cycle; the counter runs 0..31.
  - When the counter reaches 31, go to DONE.
  - The counter wraps to 0 on exit.
- **DONE.** Assert done=1 and drive result for exactly one cycle, then return to IDLE unconditionally.
  - start is ignored in DONE; the same instruction is still in EX.

Operand handling:
- Signed operands are converted to magnitudes:
  - MUL/MULH/DIV/REM: both operands.
  - MULHSU: opv1 only.
  - MULHU/DIVU/REMU: none.
- **Multiply:** shift-add over the multiplier bits, LSB first, giving a 64-bit unsigned product.
- **Divide:** restoring division, MSB first. Each cycle shifts the partial remainder left by one and subtracts the divisor. The quotient bit is 1 if the subtraction does not borrow, in which case the remainder is replaced by the difference.

Sign fix-up, applied in DONE:
- Product: negate the 64-bit product if the operand signs differ (MULHSU: if opv1 is negative).
- Quotient: negate if the operand signs differ.
- Remainder: takes the sign of the dividend.

Result selection:
- MUL: product[31:0].
- MULH/MULHSU/MULHU: product[63:32].
- DIV/DIVU: quotient.
- REM/REMU: remainder.

Special cases (no iteration):
- Divisor = 0: quotient = 0xFFFFFFFF and remainder = opv1, for signed and unsigned alike.
- DIV/REM with opv1 = 0x80000000 and opv2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

annul:
- Has priority over start and over every state transition.
- The next cycle is IDLE with stall_req=0, done=0 and result=0.
- No done pulse is produced for the aborted operation.

rst: same effect as annul, and additionally clears all datapath registers.

## Timing

- stall_req is combinational:
  - 1 in IDLE when start=1 and annul=0.
  - 1 in CALC.
  - 0 in DONE, so the pipeline advances with the result on the done cycle.
- Normal operation accepted in cycle N:
  - CALC occupies cycles N+1..N+32.
  - done=1 in cycle N+33.
  - IDLE from N+34.
  - stall_req is high for cycles N..N+32, i.e. 33 cycles.
- Special case accepted in cycle N: done=1 in cycle N+1; stall_req is high in cycle N only.
- Back-to-back operations: the next start is accepted in the first IDLE cycle after DONE, with no bubble beyond that cycle.
- Operands and op are registered in cycle N; changes on opv1/opv2/op after acceptance have no effect.
- annul in the same cycle as start in IDLE: the operation is not accepted, stall_req=0 and the state stays IDLE.

## Test plan

- **MUL signed:** start with op=0, opv1=7, opv2=0xFFFFFFFD at cycle N -> done at N+33, result 0xFFFFFFEB; stall_req high N..N+32.
- **High products:**
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- **Signed divide:**
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- **Special cases:**
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - All of these give done at N+1.
- **Flush:** start DIV 1000/3, assert annul at cycle N+10 -> cycle N+11 is IDLE, stall_req=0, done never pulses. A new MUL 6×7 started at N+11 gives done at N+44 with result 42.
- **Reset and hold:**
  - Assert rst mid-CALC -> next cycle all outputs 0.
  - Hold start high through DONE -> exactly one done pulse, and the operation restarts only on the IDLE cycle after DONE.
